// File: rtl/multiplier_control_if.sv
// -----------------------------------------------------------------------------
// multiplier_control_if
// Groups the handshake and control strobes between the shift-add multiplier
// sequencer and its surroundings (switch/run inputs, datapath control lines).
//
// Signals:
//   Run           active-low start request (debounced, synchronized upstream)
//   ClearA_LoadB  active-low request to clear A/X and load B from switches
//   M             current multiplier bit B[0] from the datapath
//   ClrA_X        clear accumulator A and sign bit X this cycle
//   LdB           load register B from switches this cycle
//   Add / Sub     A/X <= A +/- S (sign-extended) this cycle
//   Shift         arithmetic right shift of X:A:B this cycle
//   Busy          multiplication in progress
//   Done          result valid in A:B, waiting for Run release
//   Count         current bit index (debug)
//
// Modports:
//   master  drives the requests and M, observes the control strobes
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface multiplier_control_if;
    logic       Run;
    logic       ClearA_LoadB;
    logic       M;
    logic       ClrA_X;
    logic       LdB;
    logic       Add;
    logic       Sub;
    logic       Shift;
    logic       Busy;
    logic       Done;
    logic [2:0] Count;

    modport master (
        output Run, ClearA_LoadB, M,
        input  ClrA_X, LdB, Add, Sub, Shift, Busy, Done, Count
    );

    modport slave (
        input  Run, ClearA_LoadB, M,
        output ClrA_X, LdB, Add, Sub, Shift, Busy, Done, Count
    );
endinterface

// File: rtl/multiplier_control.sv
// -----------------------------------------------------------------------------
// multiplier_control
// Sequencer for an 8x8 signed shift-add multiplier. One Run press performs a
// clear of A/X, then eight ADD/SHIFT pairs (the last ADD subtracts, since the
// multiplier MSB carries negative weight in two's complement), then waits in
// HALT with Done raised until Run is released.
//
// Ports:
//   Clk    system clock, rising edge
//   Reset  synchronous active-low reset
//   bus    multiplier_control_if.slave (requests in, control strobes out)
// -----------------------------------------------------------------------------
module multiplier_control (
    input  logic                 Clk,
    input  logic                 Reset,
    multiplier_control_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    state_t     out_state_s;
    logic [2:0] count_r;
    logic [2:0] count_next_s;

    // State and bit-index registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r <= IDLE;
            count_r <= 3'd0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
        end
    end

    // Next-state and next-count logic.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        case (state_r)
            IDLE: begin
                // A pending load takes priority over a start request.
                if (!bus.ClearA_LoadB) begin
                    state_next_s = IDLE;
                end else if (!bus.Run) begin
                    state_next_s = CLR;
                    count_next_s = 3'd0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CLR: begin
                state_next_s = ADD;
            end
            ADD: begin
                state_next_s = SHIFT;
            end
            SHIFT: begin
                if (count_r == 3'd7) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = ADD;
                    count_next_s = count_r + 3'd1;
                end
            end
            HALT: begin
                // Stay here until Run is released so one press gives one product.
                if (bus.Run) begin
                    state_next_s = IDLE;
                    count_next_s = 3'd0;
                end else begin
                    state_next_s = HALT;
                end
            end
            default: begin
                state_next_s = IDLE;
                count_next_s = 3'd0;
            end
        endcase
    end

    // While Reset is held low the strobes decode as if idle, so a reset that
    // lands mid-run never drives datapath operations during the reset cycle.
    always_comb begin
        if (Reset) begin
            out_state_s = state_r;
        end else begin
            out_state_s = IDLE;
        end
    end

    // Output decode; everything not asserted in a state stays 0.
    always_comb begin
        bus.ClrA_X = 1'b0;
        bus.LdB    = 1'b0;
        bus.Add    = 1'b0;
        bus.Sub    = 1'b0;
        bus.Shift  = 1'b0;
        bus.Busy   = 1'b0;
        bus.Done   = 1'b0;
        case (out_state_s)
            IDLE: begin
                if (!bus.ClearA_LoadB) begin
                    bus.ClrA_X = 1'b1;
                    bus.LdB    = 1'b1;
                end else begin
                    bus.ClrA_X = 1'b0;
                    bus.LdB    = 1'b0;
                end
            end
            CLR: begin
                bus.ClrA_X = 1'b1;
                bus.Busy   = 1'b1;
            end
            ADD: begin
                bus.Busy = 1'b1;
                // The sign bit (index 7) is subtracted; lower bits are added.
                if (count_r == 3'd7) begin
                    bus.Sub = bus.M;
                end else begin
                    bus.Add = bus.M;
                end
            end
            SHIFT: begin
                bus.Shift = 1'b1;
                bus.Busy  = 1'b1;
            end
            HALT: begin
                bus.Done = 1'b1;
            end
            default: begin
                bus.Done = 1'b0;
            end
        endcase
    end

    assign bus.Count = count_r;

endmodule

// File: doc/multiplier_control.md
MULTIPLIER_CONTROL -- requirements
Module: multiplier_control

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-002 Port Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port Reset  input  1  synchronous active-low reset; sampled low at a rising Clk edge resets the block.
REQ-004 Port Run  input  1  active-low start request, debounced and synchronized upstream.
REQ-005 Port ClearA_LoadB  input  1  active-low request to clear A/X and load B from switches.
REQ-006 Port M  input  1  current multiplier bit (B[0]) from the datapath.
REQ-007 Port ClrA_X  output  1  clear accumulator A and sign bit X this cycle.
REQ-008 Port LdB  output  1  load register B from switches this cycle.
REQ-009 Port Add  output  1  A/X <= A + S (sign-extended) this cycle.
REQ-010 Port Sub  output  1  A/X <= A - S (sign-extended) this cycle.
REQ-011 Port Shift  output  1  arithmetic right shift of X:A:B this cycle.
REQ-012 Port Busy  output  1  multiplication in progress.
REQ-013 Port Done  output  1  result valid in A:B, waiting for Run release.
REQ-014 Port Count  output  3  current bit index (0-7), debug.

Function
REQ-015 The FSM SHALL have states IDLE, CLR, ADD, SHIFT, HALT; Count SHALL be a 3-bit registered counter.
REQ-016 IDLE, ClearA_LoadB=0: ClrA_X=1 and LdB=1 combinationally that cycle; state stays IDLE.
REQ-017 IDLE, ClearA_LoadB=1, Run=0: next state CLR, Count <= 0.
REQ-018 IDLE, ClearA_LoadB=0 and Run=0 together: load wins; Run ignored that cycle; state stays IDLE.
REQ-019 CLR: ClrA_X=1, Busy=1; next state ADD.
REQ-020 ADD: Busy=1; Add=M when Count<7; Sub=M when Count==7; Add and Sub never both 1; next state SHIFT.
REQ-021 SHIFT: Shift=1, Busy=1; Count<7 -> Count+1, next ADD; Count==7 -> next HALT, Count holds 7.
REQ-022 HALT: Done=1, Busy=0; Run=0 -> stay HALT; Run=1 -> IDLE, Count <= 0.
REQ-023 Latency: Run sampled low in IDLE at edge 0 -> CLR cycle 1, ADD/SHIFT pairs cycles 2-17, Done=1 from cycle 18.
REQ-024 A run SHALL issue exactly 1 ClrA_X, 8 Shift, and 8 ADD-state cycles; one new multiplication per Run press.
REQ-025 ClearA_LoadB SHALL be ignored outside IDLE (LdB=0, ClrA_X only from CLR).
REQ-026 M SHALL be sampled only in ADD; its value in other states has no effect.
REQ-027 Outputs not named as asserted in a state SHALL be 0 in that state.

Reset
REQ-028 Reset=0 at an edge: state IDLE, Count=0 regardless of current state, including mid-run.
REQ-029 While in reset and the cycle after: ClrA_X, LdB, Add, Sub, Shift, Busy, Done SHALL be 0 unless ClearA_LoadB=0 in IDLE.
REQ-030 After reset, Run held low SHALL start a run on the first edge with Reset=1.

Verification
REQ-031 Reset=0 two cycles, Run=1, ClearA_LoadB=1 -> IDLE, Count=0, all outputs 0.
REQ-032 IDLE, ClearA_LoadB=0 one cycle with bench datapath model, SW=8'hFF -> LdB=1 and ClrA_X=1 that cycle; B=8'hFF, A=8'h00, Busy=0.
REQ-033 B=8'hFF, SW=8'h01, Run=0 held -> 7 Add, 1 Sub (Count=7), 8 Shift; Done=1 at cycle 18; A:B=8'hFF:8'hFF.
REQ-034 From 033, SW=8'hFF, Run released then pressed -> A:B=8'h00:8'h01; then SW=8'h0F -> A:B=8'h00:8'h0F; then SW=8'hFF -> A:B=8'hFF:8'hF1.
REQ-035 Run held low after Done for 10 cycles -> stays HALT, no extra Add/Shift; Run=1 -> IDLE next edge.
REQ-036 Reset=0 when Count=4 in SHIFT -> next edge IDLE, Count=0, Busy=0; ClearA_LoadB=0 during a run -> LdB stays 0.
